// File: rtl/mc_control_unit_if.sv
// Control/datapath bundle for the multicycle control unit: opcode/flags in, datapath strobes out.
interface mc_control_unit_if;
  logic [3:0] opcode;
  logic       zero;
  logic       memReady;
  logic       pcWrite;
  logic       pcSrc;
  logic       irWrite;
  logic       memRead;
  logic       memWrite;
  logic       regWrite;
  logic [1:0] regDst;
  logic       memToReg;
  logic       pcToReg;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       halted;
  logic       fault;
  logic       illegalOp;
  logic [3:0] state;

  modport master (
    input  opcode, zero, memReady,
    output pcWrite, pcSrc, irWrite, memRead, memWrite, regWrite, regDst, memToReg, pcToReg,
           aluSrcB, aluOp, halted, fault, illegalOp, state
  );

  modport slave (
    output opcode, zero, memReady,
    input  pcWrite, pcSrc, irWrite, memRead, memWrite, regWrite, regDst, memToReg, pcToReg,
           aluSrcB, aluOp, halted, fault, illegalOp, state
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle control FSM for the 16-bit processor, with a memory-ready stall timeout that
// drops into a sticky FAULT state.
module mc_control_unit #(
  parameter logic [3:0]  HALT_OP  = 4'hF,
  parameter int unsigned WAIT_MAX = 15
) (
  input logic               clock,
  input logic               reset_n,
  mc_control_unit_if.master bus
);

  localparam int unsigned    CntW      = (WAIT_MAX > 15) ? $clog2(WAIT_MAX + 1) : 4;
  localparam bit             TimeoutEn = (WAIT_MAX != 0);
  localparam logic [CntW-1:0] WaitLast = TimeoutEn ? CntW'(WAIT_MAX - 1) : '0;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StMemAddr = 4'd4,
    StMemRd   = 4'd5,
    StMemWr   = 4'd6,
    StWbAlu   = 4'd7,
    StWbMem   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StHalt    = 4'd11,
    StFault   = 4'd12
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rflag_q, rflag_d;

  logic       pc_write, pc_src, ir_write, mem_read, mem_write, reg_write;
  logic [1:0] reg_dst, alu_src_b, alu_op;
  logic       mem_to_reg, pc_to_reg, halted, fault, illegal_op;
  logic       stalled, timeout;

  assign stalled = (state_q inside {StFetch, StMemRd, StMemWr}) && !bus.memReady;
  assign timeout = TimeoutEn && stalled && (cnt_q == WaitLast);

  always_comb begin
    state_d    = state_q;
    rflag_d    = rflag_q;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    halted     = 1'b0;
    fault      = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd2;
        if (bus.memReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        if (bus.opcode == HALT_OP) begin
          state_d = StHalt;
        end else begin
          case (bus.opcode)
            4'd0, 4'd1, 4'd2, 4'd3: state_d = StExecR;
            4'd4:                   state_d = StExecI;
            4'd5, 4'd6:             state_d = StMemAddr;
            4'd7, 4'd8:             state_d = StBranch;
            4'd9, 4'd10:            state_d = StJump;
            default: begin
              illegal_op = 1'b1;
              state_d    = StFetch;
            end
          endcase
        end
      end
      StExecR: begin
        alu_op  = 2'd2;
        rflag_d = 1'b1;
        state_d = StWbAlu;
      end
      StExecI: begin
        alu_src_b = 2'd1;
        rflag_d   = 1'b0;
        state_d   = StWbAlu;
      end
      StWbAlu: begin
        reg_write = 1'b1;
        reg_dst   = rflag_q ? 2'd0 : 2'd1;
        state_d   = StFetch;
      end
      StMemAddr: begin
        alu_src_b = 2'd1;
        state_d   = (bus.opcode == 4'd5) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        if (bus.memReady) state_d = StWbMem;
      end
      StMemWr: begin
        mem_write = 1'b1;
        if (bus.memReady) state_d = StFetch;
      end
      StWbMem: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_op   = 2'd1;
        pc_src   = 1'b1;
        pc_write = (bus.opcode == 4'd8) ? !bus.zero : bus.zero;
        state_d  = StFetch;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = 1'b1;
        // JAL links the PC that FETCH already advanced.
        if (bus.opcode == 4'd10) begin
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          pc_to_reg = 1'b1;
        end
        state_d = StFetch;
      end
      StHalt:  halted = 1'b1;
      StFault: fault  = 1'b1;
      default: state_d = StFetch;
    endcase
    if (timeout) state_d = StFault;
  end

  // Counts consecutive not-ready cycles; any state change or ready restarts it.
  assign cnt_d = (stalled && (state_d == state_q)) ? cnt_q + 1'b1 : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      rflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rflag_q <= rflag_d;
    end
  end

  assign bus.pcWrite   = pc_write & reset_n;
  assign bus.irWrite   = ir_write & reset_n;
  assign bus.memRead   = mem_read & reset_n;
  assign bus.memWrite  = mem_write & reset_n;
  assign bus.regWrite  = reg_write & reset_n;
  assign bus.illegalOp = illegal_op & reset_n;
  assign bus.pcSrc     = pc_src;
  assign bus.regDst    = reg_dst;
  assign bus.memToReg  = mem_to_reg;
  assign bus.pcToReg   = pc_to_reg;
  assign bus.aluSrcB   = alu_src_b;
  assign bus.aluOp     = alu_op;
  assign bus.halted    = halted;
  assign bus.fault     = fault;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level reference model checked every cycle, plus
// directed literal expectations along the instruction sequences.
module tb_mc_control_unit;

  localparam int unsigned WaitMax = 15;

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_MEM_ADDR = 4;
  localparam int S_MEM_RD = 5, S_MEM_WR = 6, S_WB_ALU = 7, S_WB_MEM = 8, S_BRANCH = 9;
  localparam int S_JUMP = 10, S_HALT = 11, S_FAULT = 12;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_J = 5, C_HALT = 6;
  localparam int C_ILL = 7;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, pc_src, ir_write, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg, pc_to_reg;
    logic [1:0] alu_src_b, alu_op;
    logic       halted, fault, illegal_op;
  } outs_t;

  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en = 1'b0;

  int   m_state = 0;
  int   m_stall = 0;
  bit   m_last_r = 1'b0;
  outs_t exp_o, act_o;

  mc_control_unit_if bus ();

  mc_control_unit #(
    .HALT_OP (4'hF),
    .WAIT_MAX(WaitMax)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic int op_class(input logic [3:0] op);
    if (op == 4'hF) return C_HALT;
    if (op <= 4'd3) return C_R;
    if (op == 4'd4) return C_I;
    if (op == 4'd5) return C_LW;
    if (op == 4'd6) return C_SW;
    if (op == 4'd7 || op == 4'd8) return C_BR;
    if (op == 4'd9 || op == 4'd10) return C_J;
    return C_ILL;
  endfunction

  function automatic bit is_stalled(input int st, input logic mr);
    return (st == S_FETCH || st == S_MEM_RD || st == S_MEM_WR) && !mr;
  endfunction

  function automatic int model_next(input int st, input logic [3:0] op, input logic mr,
                                    input int stall);
    if (is_stalled(st, mr) && WaitMax != 0 && stall + 1 == int'(WaitMax)) return S_FAULT;
    case (st)
      S_FETCH: return mr ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_class(op))
          C_R:        return S_EXEC_R;
          C_I:        return S_EXEC_I;
          C_LW, C_SW: return S_MEM_ADDR;
          C_BR:       return S_BRANCH;
          C_J:        return S_JUMP;
          C_HALT:     return S_HALT;
          default:    return S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: return S_WB_ALU;
      S_MEM_ADDR: return (op_class(op) == C_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   return mr ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   return mr ? S_FETCH : S_MEM_WR;
      S_HALT:     return S_HALT;
      S_FAULT:    return S_FAULT;
      default:    return S_FETCH;
    endcase
  endfunction

  function automatic outs_t exp_outs(input int st, input logic [3:0] op, input logic z,
                                     input logic mr, input logic rn, input bit last_r);
    outs_t o;
    o = '0;
    o.state = 4'(st);
    case (st)
      S_FETCH: begin
        o.mem_read  = 1'b1;
        o.alu_src_b = 2'd2;
        o.ir_write  = mr;
        o.pc_write  = mr;
      end
      S_DECODE:   o.illegal_op = (op_class(op) == C_ILL);
      S_EXEC_R:   o.alu_op = 2'd2;
      S_EXEC_I:   o.alu_src_b = 2'd1;
      S_WB_ALU: begin
        o.reg_write = 1'b1;
        o.reg_dst   = last_r ? 2'd0 : 2'd1;
      end
      S_MEM_ADDR: o.alu_src_b = 2'd1;
      S_MEM_RD:   o.mem_read = 1'b1;
      S_MEM_WR:   o.mem_write = 1'b1;
      S_WB_MEM: begin
        o.reg_write  = 1'b1;
        o.reg_dst    = 2'd1;
        o.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        o.alu_op   = 2'd1;
        o.pc_src   = 1'b1;
        o.pc_write = (op == 4'd7) ? z : !z;
      end
      S_JUMP: begin
        o.pc_write = 1'b1;
        o.pc_src   = 1'b1;
        if (op == 4'd10) begin
          o.reg_write = 1'b1;
          o.reg_dst   = 2'd2;
          o.pc_to_reg = 1'b1;
        end
      end
      S_HALT:  o.halted = 1'b1;
      S_FAULT: o.fault = 1'b1;
      default: o = '0;
    endcase
    if (!rn) begin
      o.pc_write   = 1'b0;
      o.ir_write   = 1'b0;
      o.mem_read   = 1'b0;
      o.mem_write  = 1'b0;
      o.reg_write  = 1'b0;
      o.illegal_op = 1'b0;
    end
    return o;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= S_FETCH;
      m_stall <= 0;
    end else begin
      m_state  <= model_next(m_state, bus.opcode, bus.memReady, m_stall);
      m_stall  <= is_stalled(m_state, bus.memReady) ? m_stall + 1 : 0;
      m_last_r <= (m_state == S_EXEC_R) ? 1'b1 : (m_state == S_EXEC_I) ? 1'b0 : m_last_r;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        exp_o = exp_outs(m_state, bus.opcode, bus.zero, bus.memReady, reset_n, m_last_r);
        act_o = '{state: bus.state, pc_write: bus.pcWrite, pc_src: bus.pcSrc,
                  ir_write: bus.irWrite, mem_read: bus.memRead, mem_write: bus.memWrite,
                  reg_write: bus.regWrite, reg_dst: bus.regDst, mem_to_reg: bus.memToReg,
                  pc_to_reg: bus.pcToReg, alu_src_b: bus.aluSrcB, alu_op: bus.aluOp,
                  halted: bus.halted, fault: bus.fault, illegal_op: bus.illegalOp};
        n_checks++;
        if (act_o !== exp_o) begin
          n_errors++;
          $display("FAIL cycle_outputs t=%0t model_state=%0d: got %h expected %h",
                   $time, m_state, act_o, exp_o);
        end
      end
    end
  end

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] op, input logic z, input logic mr);
    @(posedge clock);
    #2;
    bus.opcode   = op;
    bus.zero     = z;
    bus.memReady = mr;
    @(negedge clock);
    #1;
  endtask

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       pw;
  } br_vec_t;

  br_vec_t br_vecs[4] = '{'{4'd7, 1'b1, 1'b1}, '{4'd7, 1'b0, 1'b0},
                          '{4'd8, 1'b1, 1'b0}, '{4'd8, 1'b0, 1'b1}};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n      = 1'b0;
    bus.opcode   = 4'd0;
    bus.zero     = 1'b0;
    bus.memReady = 1'b1;
    chk_en       = 1'b1;
    #1;
    check_lit("reset_state", bus.state, 0);
    check_lit("reset_pcwrite", bus.pcWrite, 0);
    check_lit("reset_memread", bus.memRead, 0);
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(negedge clock);
    #1;

    // ADD: 0,1,2,7,0
    check_lit("add_s0", bus.state, 0);
    check_lit("add_pcwrite0", bus.pcWrite, 1);
    check_lit("add_pcsrc0", bus.pcSrc, 0);
    cyc(4'd0, 1'b0, 1'b1);
    check_lit("add_s1", bus.state, 1);
    check_lit("add_pcwrite1", bus.pcWrite, 0);
    cyc(4'd0, 1'b0, 1'b1);
    check_lit("add_s2", bus.state, 2);
    cyc(4'd0, 1'b0, 1'b1);
    check_lit("add_s7", bus.state, 7);
    check_lit("add_regwrite", bus.regWrite, 1);
    check_lit("add_regdst", bus.regDst, 0);
    cyc(4'd0, 1'b0, 1'b1);
    check_lit("add_back_fetch", bus.state, 0);

    // LW with three stalled cycles in MEM_RD
    cyc(4'd5, 1'b0, 1'b1);
    cyc(4'd5, 1'b0, 1'b1);
    check_lit("lw_memaddr", bus.state, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(4'd5, 1'b0, (i == 3));
      check_lit("lw_memrd_hold", bus.state, 5);
    end
    cyc(4'd5, 1'b0, 1'b1);
    check_lit("lw_wbmem", bus.state, 8);
    check_lit("lw_regwrite", bus.regWrite, 1);
    check_lit("lw_memtoreg", bus.memToReg, 1);
    check_lit("lw_regdst", bus.regDst, 1);
    cyc(4'd5, 1'b0, 1'b1);
    check_lit("lw_fetch", bus.state, 0);

    // BEQ/BNE with both zero values
    foreach (br_vecs[k]) begin
      cyc(br_vecs[k].op, br_vecs[k].z, 1'b1);
      cyc(br_vecs[k].op, br_vecs[k].z, 1'b1);
      check_lit("br_state", bus.state, 9);
      check_lit("br_pcwrite", bus.pcWrite, {7'd0, br_vecs[k].pw});
      check_lit("br_pcsrc", bus.pcSrc, 1);
      cyc(br_vecs[k].op, br_vecs[k].z, 1'b1);
    end

    // JAL
    cyc(4'd10, 1'b0, 1'b1);
    cyc(4'd10, 1'b0, 1'b1);
    check_lit("jal_state", bus.state, 10);
    check_lit("jal_pcwrite", bus.pcWrite, 1);
    check_lit("jal_pcsrc", bus.pcSrc, 1);
    check_lit("jal_regwrite", bus.regWrite, 1);
    check_lit("jal_regdst", bus.regDst, 2);
    check_lit("jal_pctoreg", bus.pcToReg, 1);
    cyc(4'd10, 1'b0, 1'b1);
    check_lit("jal_fetch", bus.state, 0);

    // ADDI: writeback selects rt
    cyc(4'd4, 1'b0, 1'b1);
    cyc(4'd4, 1'b0, 1'b1);
    check_lit("addi_exec", bus.state, 3);
    cyc(4'd4, 1'b0, 1'b1);
    check_lit("addi_regdst", bus.regDst, 1);
    cyc(4'd4, 1'b0, 1'b1);

    // SW with two stalls, then J
    cyc(4'd6, 1'b0, 1'b1);
    cyc(4'd6, 1'b0, 1'b1);
    cyc(4'd6, 1'b0, 1'b0);
    check_lit("sw_memwr", bus.state, 6);
    check_lit("sw_memwrite", bus.memWrite, 1);
    cyc(4'd6, 1'b0, 1'b0);
    cyc(4'd6, 1'b0, 1'b1);
    cyc(4'd6, 1'b0, 1'b1);
    check_lit("sw_fetch", bus.state, 0);
    cyc(4'd9, 1'b0, 1'b1);
    cyc(4'd9, 1'b0, 1'b1);
    check_lit("j_regwrite", bus.regWrite, 0);
    cyc(4'd9, 1'b0, 1'b1);

    // Illegal opcode, then a FETCH timeout
    cyc(4'd12, 1'b0, 1'b1);
    check_lit("ill_pulse", bus.illegalOp, 1);
    cyc(4'd0, 1'b0, 1'b0);
    check_lit("ill_fetch", bus.state, 0);
    check_lit("ill_pulse_end", bus.illegalOp, 0);
    for (int k = 2; k <= 15; k++) cyc(4'd0, 1'b0, 1'b0);
    check_lit("to_15th_still_fetch", bus.state, 0);
    check_lit("to_15th_no_fault", bus.fault, 0);
    cyc(4'd0, 1'b0, 1'b0);
    check_lit("to_fault_state", bus.state, 12);
    check_lit("to_fault_flag", bus.fault, 1);
    cyc(4'd0, 1'b0, 1'b1);
    check_lit("to_fault_sticky", bus.fault, 1);

    // Reset out of FAULT, then ready on the 15th stalled cycle
    #2;
    reset_n = 1'b0;
    #1;
    check_lit("fault_rst_state", bus.state, 0);
    check_lit("fault_rst_flag", bus.fault, 0);
    @(posedge clock);
    #2;
    reset_n      = 1'b1;
    bus.memReady = 1'b0;
    @(negedge clock);
    #1;
    for (int k = 2; k <= 14; k++) cyc(4'd0, 1'b0, 1'b0);
    cyc(4'd0, 1'b0, 1'b1);
    check_lit("ready_on_limit_no_fault", bus.fault, 0);
    cyc(4'd15, 1'b0, 1'b1);
    check_lit("ready_on_limit_decode", bus.state, 1);

    // HALT absorbs even with memReady low
    for (int k = 0; k < 22; k++) begin
      cyc(4'd15, 1'b0, 1'b0);
      check_lit("halt_state", bus.state, 11);
      check_lit("halt_flag", bus.halted, 1);
    end

    // Reset asserted during WB_ALU
    #2;
    reset_n = 1'b0;
    #1;
    check_lit("halt_rst_state", bus.state, 0);
    @(posedge clock);
    #2;
    reset_n      = 1'b1;
    bus.opcode   = 4'd1;
    bus.memReady = 1'b1;
    @(negedge clock);
    #1;
    cyc(4'd1, 1'b0, 1'b1);
    cyc(4'd1, 1'b0, 1'b1);
    cyc(4'd1, 1'b0, 1'b1);
    check_lit("mid_wb_regwrite", bus.regWrite, 1);
    reset_n = 1'b0;
    #1;
    check_lit("mid_rst_regwrite", bus.regWrite, 0);
    check_lit("mid_rst_state", bus.state, 0);
    check_lit("mid_rst_memread", bus.memRead, 0);
    @(posedge clock);
    #2;
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    cyc(4'd13, 1'b0, 1'b1);
    check_lit("ill13_pulse", bus.illegalOp, 1);
    cyc(4'd0, 1'b0, 1'b1);
    check_lit("ill13_fetch", bus.state, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
